// File: rtl/xtop.sv
// xtop: PS/2 keyboard hex calculator with a four-digit multiplexed 7-segment display.
// Keys enter hex digits, three operator keys (add/sub/mul) and Enter drive a
// 16-bit accumulator. push_C clears the entry and push_AC clears everything.
// The last accepted make code is shown on gpo_out.
// Build option: define PS2_PARITY_CHECK_EN to discard frames with bad odd parity.
// Without it, the parity bit is received and then ignored.
module xtop (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic        push_AC,
    input  logic        push_C,
    output logic [11:0] disp_ctrl,
    output logic [7:0]  gpo_out
);

    // Synchronizer chains. In the 3-bit chains, bit 2 is the previous
    // synchronized value, kept for edge detection.
    logic [2:0]  r_sync_pc;
    logic [1:0]  r_sync_pd;
    logic [2:0]  r_sync_ac;
    logic [2:0]  r_sync_c;

    // Receiver state
    logic [3:0]  r_bitcnt;
    logic [7:0]  r_shift;
    logic [13:0] r_tmo;
    logic        r_done;
    logic        r_strobe;
    logic [7:0]  r_byte;
`ifdef PS2_PARITY_CHECK_EN
    logic        r_par;
`endif

    // Calculator state
    logic [15:0] r_e;
    logic [15:0] r_a;
    logic [1:0]  r_p;
    logic [7:0]  r_code;
    logic        r_brk;
    logic        r_show;
    logic [15:0] r_scan;

    logic        w_pc_fall;
    logic        w_pd;
    logic        w_ac_rise;
    logic        w_c_rise;
    logic        w_par_ok;
    logic        w_is_digit;
    logic [3:0]  w_digit;
    logic [1:0]  w_op;
    logic [15:0] w_val;
    logic [3:0]  w_nib;
    logic [6:0]  w_seg;
    logic [1:0]  w_sel;
    logic [15:0] w_reg_1 [16];

    assign w_pc_fall = r_sync_pc[2] & ~r_sync_pc[1];
    assign w_pd      = r_sync_pd[1];
    assign w_ac_rise = r_sync_ac[1] & ~r_sync_ac[2];
    assign w_c_rise  = r_sync_c[1]  & ~r_sync_c[2];

`ifdef PS2_PARITY_CHECK_EN
    assign w_par_ok = ^{r_par, r_shift};
`else
    assign w_par_ok = 1'b1;
`endif

    // Register-file view (regf.reg_1): entries 0..3 map onto live state; the rest read as zero.
    for (genvar gi = 0; gi < 16; gi++) begin : g_regf
        if (gi == 0) begin : g_e
            assign w_reg_1[gi] = r_e;
        end else if (gi == 1) begin : g_a
            assign w_reg_1[gi] = r_a;
        end else if (gi == 2) begin : g_p
            assign w_reg_1[gi] = {14'd0, r_p};
        end else if (gi == 3) begin : g_code
            assign w_reg_1[gi] = {8'd0, r_code};
        end else begin : g_zero
            assign w_reg_1[gi] = 16'd0;
        end
    end

    // Bring the asynchronous inputs into the clk domain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync_pc <= 3'b000;
            r_sync_pd <= 2'b00;
            r_sync_ac <= 3'b000;
            r_sync_c  <= 3'b000;
        end else begin
            r_sync_pc <= {r_sync_pc[1:0], ps2_clk};
            r_sync_pd <= {r_sync_pd[0], ps2_data};
            r_sync_ac <= {r_sync_ac[1:0], push_AC};
            r_sync_c  <= {r_sync_c[1:0], push_C};
        end
    end

    // PS/2 frame receiver. The byte strobe fires two cycles after the stop-bit sample.
    // A stalled frame returns to idle after 16384 cycles without a clock edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bitcnt <= 4'd0;
            r_shift  <= 8'd0;
            r_tmo    <= 14'd0;
            r_done   <= 1'b0;
            r_strobe <= 1'b0;
            r_byte   <= 8'd0;
`ifdef PS2_PARITY_CHECK_EN
            r_par    <= 1'b0;
`endif
        end else begin
            r_done   <= 1'b0;
            r_strobe <= r_done;
            if (w_pc_fall) begin
                r_tmo <= 14'd0;
                if (r_bitcnt == 4'd0) begin
                    if (!w_pd) begin
                        r_bitcnt <= 4'd1;
                    end
                end else if (r_bitcnt == 4'd9) begin
`ifdef PS2_PARITY_CHECK_EN
                    r_par <= w_pd;
`endif
                    r_bitcnt <= 4'd10;
                end else if (r_bitcnt == 4'd10) begin
                    r_bitcnt <= 4'd0;
                    if (w_pd && w_par_ok) begin
                        r_done <= 1'b1;
                        r_byte <= r_shift;
                    end
                end else begin
                    r_shift  <= {w_pd, r_shift[7:1]};
                    r_bitcnt <= r_bitcnt + 4'd1;
                end
            end else if (r_bitcnt != 4'd0) begin
                if (r_tmo == 14'h3FFF) begin
                    r_bitcnt <= 4'd0;
                    r_tmo    <= 14'd0;
                end else begin
                    r_tmo <= r_tmo + 14'd1;
                end
            end
        end
    end

    // Decode the received byte into a hex digit or an operator code.
    always_comb begin
        w_is_digit = 1'b1;
        w_digit    = 4'h0;
        w_op       = 2'd0;
        case (r_byte)
            8'h45: w_digit = 4'h0;
            8'h16: w_digit = 4'h1;
            8'h1E: w_digit = 4'h2;
            8'h26: w_digit = 4'h3;
            8'h25: w_digit = 4'h4;
            8'h2E: w_digit = 4'h5;
            8'h36: w_digit = 4'h6;
            8'h3D: w_digit = 4'h7;
            8'h3E: w_digit = 4'h8;
            8'h46: w_digit = 4'h9;
            8'h1C: w_digit = 4'hA;
            8'h32: w_digit = 4'hB;
            8'h21: w_digit = 4'hC;
            8'h23: w_digit = 4'hD;
            8'h24: w_digit = 4'hE;
            8'h2B: w_digit = 4'hF;
            default: w_is_digit = 1'b0;
        endcase
        case (r_byte)
            8'h79:   w_op = 2'd1;
            8'h7B:   w_op = 2'd2;
            8'h7C:   w_op = 2'd3;
            default: w_op = 2'd0;
        endcase
    end

    function automatic logic [15:0] f_alu(input logic [15:0] a, input logic [1:0] p,
                                          input logic [15:0] e);
        case (p)
            2'd1:    f_alu = a + e;
            2'd2:    f_alu = a - e;
            2'd3:    f_alu = a * e;
            default: f_alu = a;
        endcase
    endfunction

    // Calculator update. Priority is AC, then C, then a keyboard byte; a byte arriving
    // in the same cycle as a button edge is lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_e    <= 16'd0;
            r_a    <= 16'd0;
            r_p    <= 2'd0;
            r_code <= 8'd0;
            r_brk  <= 1'b0;
            r_show <= 1'b1;
        end else if (w_ac_rise) begin
            r_e    <= 16'd0;
            r_a    <= 16'd0;
            r_p    <= 2'd0;
            r_show <= 1'b1;
        end else if (w_c_rise) begin
            r_e    <= 16'd0;
            r_show <= 1'b1;
        end else if (r_strobe) begin
            if (r_byte == 8'hE0) begin
                r_brk <= r_brk;
            end else if (r_byte == 8'hF0) begin
                r_brk <= 1'b1;
            end else if (r_brk) begin
                r_brk <= 1'b0;
            end else begin
                r_code <= r_byte;
                if (w_is_digit) begin
                    r_e    <= {r_e[11:0], w_digit};
                    r_show <= 1'b1;
                end else if (w_op != 2'd0) begin
                    r_a    <= (r_p == 2'd0) ? r_e : f_alu(r_a, r_p, r_e);
                    r_p    <= w_op;
                    r_e    <= 16'd0;
                    r_show <= 1'b0;
                end else if (r_byte == 8'h5A) begin
                    r_a    <= f_alu(r_a, r_p, r_e);
                    r_p    <= 2'd0;
                    r_e    <= 16'd0;
                    r_show <= 1'b0;
                end
            end
        end
    end

    // Free-running counter; its top two bits select the digit being driven.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_scan <= 16'd0;
        end else begin
            r_scan <= r_scan + 16'd1;
        end
    end

    assign w_sel = r_scan[15:14];
    assign w_val = r_show ? w_reg_1[0] : w_reg_1[1];

    // Pick the nibble for the active digit and map it to segments (active high, gfedcba).
    always_comb begin
        case (w_sel)
            2'd0:    w_nib = w_val[3:0];
            2'd1:    w_nib = w_val[7:4];
            2'd2:    w_nib = w_val[11:8];
            default: w_nib = w_val[15:12];
        endcase
        case (w_nib)
            4'h0: w_seg = 7'h3F;
            4'h1: w_seg = 7'h06;
            4'h2: w_seg = 7'h5B;
            4'h3: w_seg = 7'h4F;
            4'h4: w_seg = 7'h66;
            4'h5: w_seg = 7'h6D;
            4'h6: w_seg = 7'h7D;
            4'h7: w_seg = 7'h07;
            4'h8: w_seg = 7'h7F;
            4'h9: w_seg = 7'h6F;
            4'hA: w_seg = 7'h77;
            4'hB: w_seg = 7'h7C;
            4'hC: w_seg = 7'h39;
            4'hD: w_seg = 7'h5E;
            4'hE: w_seg = 7'h79;
            default: w_seg = 7'h71;
        endcase
    end

    assign disp_ctrl = {~(4'b0001 << w_sel), 1'b1, ~w_seg};
    assign gpo_out   = w_reg_1[3][7:0];

endmodule

// File: tb/tb_xtop.sv
// tb_xtop: directed and random key sequences for the PS/2 hex calculator,
// compared against a behavioural calculator model.
module tb_xtop;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic        push_AC = 1'b0;
    logic        push_C = 1'b0;
    logic [11:0] disp_ctrl;
    logic [7:0]  gpo_out;

    xtop dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .push_AC   (push_AC),
        .push_C    (push_C),
        .disp_ctrl (disp_ctrl),
        .gpo_out   (gpo_out)
    );

    always #5 clk = ~clk;

    localparam int HALF = 100;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model state
    int       m_e, m_a, m_p;
    bit       m_show, m_brk;
    int       m_gpo;

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    logic [7:0] key_tab [16] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                 8'h3E, 8'h46, 8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic int digit_of(input logic [7:0] b);
        for (int i = 0; i < 16; i++) begin
            if (key_tab[i] == b) return i;
        end
        return -1;
    endfunction

    function automatic int calc(input int a, input int p, input int e);
        longint r;
        case (p)
            1: r = longint'(a) + e;
            2: r = longint'(a) - e + 65536;
            3: r = longint'(a) * e;
            default: r = a;
        endcase
        return int'(r % 65536);
    endfunction

    task automatic model_reset();
        m_e = 0; m_a = 0; m_p = 0; m_show = 1; m_brk = 0; m_gpo = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        int d;
        int op;
        if (b == 8'hE0) return;
        if (b == 8'hF0) begin m_brk = 1; return; end
        if (m_brk) begin m_brk = 0; return; end
        m_gpo = int'(b);
        d = digit_of(b);
        op = (b == 8'h79) ? 1 : (b == 8'h7B) ? 2 : (b == 8'h7C) ? 3 : 0;
        if (d >= 0) begin
            m_e = (m_e * 16 + d) % 65536;
            m_show = 1;
        end else if (op != 0) begin
            m_a = (m_p == 0) ? m_e : calc(m_a, m_p, m_e);
            m_p = op; m_e = 0; m_show = 0;
        end else if (b == 8'h5A) begin
            if (m_p != 0) m_a = calc(m_a, m_p, m_e);
            m_p = 0; m_e = 0; m_show = 0;
        end
    endtask

    // Drive one PS/2 frame; bad_par inverts the odd-parity bit.
    task automatic send_frame(input logic [7:0] b, input bit bad_par);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        @(negedge clk);
        for (int i = 0; i < 11; i++) begin
            ps2_data = f[i];
            #(HALF);
            ps2_clk = 1'b0;
            #(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (12) @(posedge clk);
    endtask

    task automatic send_partial(input int nbits);
        @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = (i == 0) ? 1'b0 : 1'b1;
            #(HALF);
            ps2_clk = 1'b0;
            #(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic key(input logic [7:0] b);
        send_frame(b, 1'b0);
        model_byte(b);
        $display("key %02h -> model E=%04h A=%04h P=%0d", b, m_e[15:0], m_a[15:0], m_p);
    endtask

    task automatic press(input bit ac);
        @(negedge clk);
        if (ac) push_AC = 1'b1; else push_C = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        push_AC = 1'b0; push_C = 1'b0;
        repeat (6) @(posedge clk);
        if (ac) begin m_e = 0; m_a = 0; m_p = 0; end
        else m_e = 0;
        m_show = 1;
        $display("push %s -> model E=%04h A=%04h", ac ? "AC" : "C", m_e[15:0], m_a[15:0]);
    endtask

    task automatic check_state(input string tag);
        logic [3:0]  en;
        int          idx;
        int          val;
        int          nib;
        @(negedge clk);
        check({tag, "_E"}, 32'(dut.w_reg_1[0]), 32'(m_e));
        check({tag, "_A"}, 32'(dut.w_reg_1[1]), 32'(m_a));
        check({tag, "_P"}, 32'(dut.w_reg_1[2]), 32'(m_p));
        check({tag, "_gpo"}, 32'(gpo_out), 32'(m_gpo));
        en = disp_ctrl[11:8];
        check({tag, "_onehot"}, 32'($countones(~en)), 32'd1);
        idx = 0;
        for (int i = 0; i < 4; i++) if (!en[i]) idx = i;
        val = m_show ? m_e : m_a;
        nib = (val >> (4 * idx)) & 15;
        check({tag, "_seg"}, 32'(disp_ctrl[7:0]), 32'({1'b1, ~seg_tab[nib]}));
    endtask

    initial begin
        int cat;
        model_reset();

        // Reset values, held in reset and just after release
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rst_disp", 32'(disp_ctrl), 32'h0000_0EC0);
        check("rst_gpo", 32'(gpo_out), 32'h0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("post_rst_disp", 32'(disp_ctrl), 32'h0000_0EC0);
        for (int i = 0; i < 16; i++)
            check($sformatf("rst_reg%0d", i), 32'(dut.w_reg_1[i]), 32'h0);

        // Digit entry
        key(8'h16); key(8'h1E); key(8'h26);
        check_state("entry");
        check("entry_const", 32'(dut.w_reg_1[0]), 32'h0123);
        check("entry_gpo", 32'(gpo_out), 32'h26);

        // Add, then wrap-around add
        press(1'b1);
        key(8'h2E); key(8'h79); key(8'h3D); key(8'h5A);
        check_state("add");
        check("add_const", 32'(dut.w_reg_1[1]), 32'h000C);
        key(8'h2B); key(8'h2B); key(8'h2B); key(8'h2B);
        key(8'h79); key(8'h1E); key(8'h5A);
        check_state("wrap");
        check("wrap_const", 32'(dut.w_reg_1[1]), 32'h0001);

        // Release code suppresses the following byte
        key(8'h26); key(8'hF0); key(8'h26); key(8'h25);
        check_state("release");
        check("release_const", 32'(dut.w_reg_1[0]), 32'h0034);

        // Clear entry mid-operation, then all-clear
        press(1'b1);
        key(8'h46); key(8'h79); key(8'h3E);
        press(1'b0);
        key(8'h1E); key(8'h5A);
        check_state("clr_entry");
        check("clr_entry_const", 32'(dut.w_reg_1[1]), 32'h000B);
        press(1'b1);
        check_state("all_clear");

        // Wrong parity frame
        send_frame(8'h16, 1'b1);
`ifndef PS2_PARITY_CHECK_EN
        model_byte(8'h16);
`endif
        check_state("parity");

        // Stalled frame must time out, then a clean frame decodes
        send_partial(4);
        repeat (16500) @(posedge clk);
        key(8'h1E);
        check_state("timeout");

        // Reset in the middle of a frame
        send_partial(5);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        key(8'h16);
        check_state("rst_mid");

        // Random traffic: digits, operators, enter, prefixes, arbitrary codes, buttons
        for (int n = 0; n < 70; n++) begin
            cat = $urandom_range(0, 11);
            if (cat <= 4) key(key_tab[$urandom_range(0, 15)]);
            else if (cat == 5) key(8'h79 + 8'($urandom_range(0, 2)) + ((cat == 5 && $urandom_range(0, 1) == 1) ? 8'h0 : 8'h0));
            else if (cat == 6) key(8'h7B + 8'($urandom_range(0, 1)));
            else if (cat == 7) key(8'h5A);
            else if (cat == 8) key(8'hF0);
            else if (cat == 9) key(8'hE0);
            else if (cat == 10) key(8'($urandom_range(0, 255)));
            else press($urandom_range(0, 3) == 0);
            check_state($sformatf("rnd%0d", n));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
